cam_lookup: RTL and testbench
=============================

// Module: cam_lookup
// PURPOSE
//  Storage-plus-lookup block: entries are written by a producer port, then read back and searched.
//  Built from SIZE-wide registers with per-entry valid bits.
//  Two consumer ports:
//   - indexed read (read_value_o/read_valid_o)
//   - content search returning the lowest matching index (search_index_o/search_valid_o).
//  Sits behind the register/ff storage layer as its consumer (read/search) end.
// PARAMETERS
//  SIZE   8  data width of each entry, bits (>=1)
//  DEPTH  8  number of entries (power of 2, >=2); IW = $clog2(DEPTH)
// PORTS
//  clk             in   1     clock; all state updates on posedge
//  reset_i         in   1     synchronous, active-high reset
//  write_i         in   1     write strobe
//  write_index_i   in   IW    entry to write
//  write_data_i    in   SIZE  data to write; entry becomes valid
//  read_i          in   1     read strobe
//  read_index_i    in   IW    entry to read
//  read_value_o    out  SIZE  registered read data
//  read_valid_o    out  1     1 = read_value_o is from a valid entry this cycle
//  search_i        in   1     search strobe
//  search_data_i   in   SIZE  key to match
//  search_index_o  out  IW    lowest index whose valid entry == key
//  search_valid_o  out  1     1 = a match was found for the search issued last cycle
// BEHAVIOUR
//  - Reset (reset_i=1 at posedge):
//     - all entry valid bits=0; storage data=0
//     - read_value_o=0, read_valid_o=0, search_index_o=0, search_valid_o=0
//     - reset overrides any write/read/search in the same cycle; in-flight results are discarded.
//  - Write: at posedge with write_i=1, mem[write_index_i]<=write_data_i and valid[write_index_i]<=1.
//    Rewriting a valid entry overwrites it. There is no invalidate port; only reset clears valid bits.
//  - Read: latency 1. read_i=1 in cycle N gives, in cycle N+1:
//     - read_value_o = mem[idx]
//     - read_valid_o = valid[idx]
//     - an invalid entry gives read_value_o=0, read_valid_o=0.
//    read_i=0: read_valid_o=0 next cycle; read_value_o holds its previous value.
//  - Search: latency 1. search_i=1 in cycle N compares the key against all DEPTH entries in parallel;
//    only valid entries participate.
//     - Match: cycle N+1 gives search_valid_o=1, search_index_o = lowest matching index
//       (priority encoder, index 0 highest priority).
//     - No match, or search_i=0: search_valid_o=0, search_index_o=0.
//  - Read and search are independent and may be issued in the same cycle as each other and as a write.
//  - Back-to-back strobes every cycle are allowed: full throughput, one result per cycle per port.
//  - Index arithmetic: indices are IW bits and always in range; there is no wrap or overflow case.
// CONFIGURATION
//  CAM_WRITE_BYPASS_EN
//   - defined: a read/search in the same cycle as a write sees the new data. A read of write_index_i
//     returns write_data_i with valid=1. The search includes write_data_i at write_index_i in place of
//     the old entry.
//   - undefined: a same-cycle read/search sees the pre-write contents. The write becomes visible to
//     strobes issued in the following cycle.
// TESTING (SIZE=8, DEPTH=8)
//  1. Assert reset_i 2 cycles, then read_i idx 3 and search_i key 8'h00
//     -> read_valid_o=0, read_value_o=0, search_valid_o=0. An all-zero key must not match empty entries.
//  2. Write 8'hA5->idx2, 8'hA5->idx5, 8'h3C->idx7, then search 8'hA5 -> next cycle search_valid_o=1,
//     search_index_o=2. Then read idx7 -> read_value_o=8'h3C, read_valid_o=1.
//  3. Same cycle: write 8'h77->idx1, search 8'h77, read idx1.
//     - bypass off -> search_valid_o=0, read_valid_o=0; repeat next cycle -> index 1, valid, 8'h77.
//     - bypass on -> first cycle already index 1 / 8'h77 valid.
//  4. Overwrite idx2 with 8'h11, then search 8'hA5 -> search_index_o=5. Search 8'hFF -> search_valid_o=0.
//  5. Issue search and read strobes every cycle for 8 cycles over indices 0..7
//     -> one registered result per cycle, matching the model.
//  6. Assert reset_i for one cycle after a search_i cycle -> search_valid_o=0 in the following cycle.
//     A read of any previously written index then gives read_valid_o=0.

Source files
------------

// File: rtl/cam_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : cam_lookup
//  Description : Storage-plus-lookup block. A producer writes SIZE-bit entries
//                into DEPTH slots, each with its own valid bit. Two
//                independent consumer ports read from those entries:
//                  - indexed read, with one cycle of latency
//                  - content search, with one cycle of latency, returning
//                    the lowest index whose valid entry equals the key
//  Ports       : clk             clock, all state updates on posedge
//                reset_i         synchronous active-high reset
//                write_i         write strobe
//                write_index_i   entry to write
//                write_data_i    data to write, which marks the entry valid
//                read_i          read strobe
//                read_index_i    entry to read
//                read_value_o    registered read data (0 for an invalid entry)
//                read_valid_o    read_value_o comes from a valid entry
//                search_i        search strobe
//                search_data_i   key to match
//                search_index_o  lowest matching index (0 if no match)
//                search_valid_o  the previous cycle's search found a match
//  Config      : CAM_WRITE_BYPASS_EN
//                  defined   - a read or search in the same cycle as a write
//                              sees the data being written
//                  undefined - a read or search in the same cycle as a write
//                              sees the contents from before that write
//  Revision    : 1.0 - initial release
// ============================================================================
module cam_lookup #(
    parameter  int SIZE  = 8,
    parameter  int DEPTH = 8,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic            write_i,
    input  logic [IW-1:0]   write_index_i,
    input  logic [SIZE-1:0] write_data_i,
    input  logic            read_i,
    input  logic [IW-1:0]   read_index_i,
    output logic [SIZE-1:0] read_value_o,
    output logic            read_valid_o,
    input  logic            search_i,
    input  logic [SIZE-1:0] search_data_i,
    output logic [IW-1:0]   search_index_o,
    output logic            search_valid_o
);

    // Storage
    logic [SIZE-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;

    // The contents that the read and search ports see this cycle. This is
    // either the stored contents, or the stored contents with this cycle's
    // write merged in.
    logic [SIZE-1:0]  w_view_mem [DEPTH];
    logic [DEPTH-1:0] w_view_valid;

    logic [DEPTH-1:0] w_wr_sel;
    logic [DEPTH-1:0] w_match;
    logic [IW-1:0]    w_match_index;
    logic             w_match_any;

    // Registered results
    logic [SIZE-1:0]  r_read_value;
    logic             r_read_valid;
    logic [IW-1:0]    r_search_index;
    logic             r_search_valid;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_wr_sel[gi] = write_i && (write_index_i == IW'(gi));
`ifdef CAM_WRITE_BYPASS_EN
            assign w_view_mem[gi]   = w_wr_sel[gi] ? write_data_i : r_mem[gi];
            assign w_view_valid[gi] = w_wr_sel[gi] | r_valid[gi];
`else
            assign w_view_mem[gi]   = r_mem[gi];
            assign w_view_valid[gi] = r_valid[gi];
`endif
            // Only valid entries take part in the search. Because of this,
            // an all-zero key never matches an empty slot.
            assign w_match[gi] = w_view_valid[gi] && (w_view_mem[gi] == search_data_i);
        end
    endgenerate

    // Priority encoder. The loop scans downward so that the last assignment,
    // which is the lowest matching index, is the one that takes effect.
    always_comb begin
        w_match_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_match_index = IW'(i);
            end
        end
    end

    assign w_match_any = |w_match;

    // Entry storage and valid bits. Only a reset clears a valid bit.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_sel[i]) begin
                    r_mem[i]   <= write_data_i;
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

    // Result registers for the read and search ports. When no read is
    // issued, the read data keeps its previous value and only the valid
    // flag drops.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_read_value   <= '0;
            r_read_valid   <= 1'b0;
            r_search_index <= '0;
            r_search_valid <= 1'b0;
        end else begin
            if (read_i) begin
                r_read_valid <= w_view_valid[read_index_i];
                r_read_value <= w_view_valid[read_index_i] ? w_view_mem[read_index_i] : '0;
            end else begin
                r_read_valid <= 1'b0;
            end
            r_search_valid <= search_i && w_match_any;
            r_search_index <= (search_i && w_match_any) ? w_match_index : '0;
        end
    end

    assign read_value_o   = r_read_value;
    assign read_valid_o   = r_read_valid;
    assign search_index_o = r_search_index;
    assign search_valid_o = r_search_valid;

endmodule
`default_nettype wire

// File: tb/tb_cam_lookup.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cam_lookup
//  Description : Self-checking bench for cam_lookup (SIZE=8, DEPTH=8). It
//                keeps a reference model of the entry array, runs directed
//                scenarios and then randomized traffic, and compares the
//                outputs after every clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_lookup;

    localparam int SIZE  = 8;
    localparam int DEPTH = 8;
    localparam int IW    = 3;

    logic            clk = 1'b0;
    logic            reset_i = 1'b1;
    logic            write_i = 1'b0;
    logic [IW-1:0]   write_index_i = '0;
    logic [SIZE-1:0] write_data_i = '0;
    logic            read_i = 1'b0;
    logic [IW-1:0]   read_index_i = '0;
    logic [SIZE-1:0] read_value_o;
    logic            read_valid_o;
    logic            search_i = 1'b0;
    logic [SIZE-1:0] search_data_i = '0;
    logic [IW-1:0]   search_index_o;
    logic            search_valid_o;

    always #5 clk = ~clk;

    cam_lookup #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .write_i        (write_i),
        .write_index_i  (write_index_i),
        .write_data_i   (write_data_i),
        .read_i         (read_i),
        .read_index_i   (read_index_i),
        .read_value_o   (read_value_o),
        .read_valid_o   (read_valid_o),
        .search_i       (search_i),
        .search_data_i  (search_data_i),
        .search_index_o (search_index_o),
        .search_valid_o (search_valid_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the contents as the producer has written them
    logic [SIZE-1:0] m_mem   [DEPTH];
    logic            m_valid [DEPTH];

    // Outputs expected after the most recent clock
    logic [SIZE-1:0] exp_rv     = '0;
    logic            exp_rvalid = 1'b0;
    logic [IW-1:0]   exp_sidx   = '0;
    logic            exp_svalid = 1'b0;

    // Drive one cycle of inputs, predict the registered outputs, advance the
    // clock, and leave the bench 1 time unit after the posedge.
    task automatic step(input logic rst, input logic w, input logic [IW-1:0] wi,
                        input logic [SIZE-1:0] wd, input logic r, input logic [IW-1:0] ri,
                        input logic s, input logic [SIZE-1:0] sk);
        logic [SIZE-1:0] v_mem   [DEPTH];
        logic            v_valid [DEPTH];
        @(negedge clk);
        reset_i = rst; write_i = w; write_index_i = wi; write_data_i = wd;
        read_i = r; read_index_i = ri; search_i = s; search_data_i = sk;
        for (int i = 0; i < DEPTH; i++) begin
            v_mem[i] = m_mem[i]; v_valid[i] = m_valid[i];
        end
`ifdef CAM_WRITE_BYPASS_EN
        if (w) begin v_mem[wi] = wd; v_valid[wi] = 1'b1; end
`endif
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_valid[i] = 1'b0; end
            exp_rv = '0; exp_rvalid = 1'b0; exp_sidx = '0; exp_svalid = 1'b0;
        end else begin
            if (r) begin
                exp_rvalid = v_valid[ri];
                exp_rv     = v_valid[ri] ? v_mem[ri] : '0;
            end else begin
                exp_rvalid = 1'b0;
            end
            exp_svalid = 1'b0; exp_sidx = '0;
            if (s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!exp_svalid && v_valid[i] && v_mem[i] == sk) begin
                        exp_svalid = 1'b1; exp_sidx = IW'(i);
                    end
                end
            end
            if (w) begin m_mem[wi] = wd; m_valid[wi] = 1'b1; end
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0; write_i = 1'b0; read_i = 1'b0; search_i = 1'b0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (read_value_o !== 8'h00) begin n_bad++; $display("FAIL reset_read_value: got %h want 00", read_value_o); end
        n_cmp++; if (read_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_read_valid: got %b want 0", read_valid_o); end
        n_cmp++; if (search_index_o !== 3'd0) begin n_bad++; $display("FAIL reset_search_index: got %0d want 0", search_index_o); end
        n_cmp++; if (search_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_search_valid: got %b want 0", search_valid_o); end
        // Read idx 3 and search for an all-zero key in the empty array
        step(0, 0, 0, 0, 1, 3, 1, 8'h00);
        n_cmp++; if (read_valid_o !== 1'b0) begin n_bad++; $display("FAIL empty_read_valid: got %b want 0", read_valid_o); end
        n_cmp++; if (read_value_o !== 8'h00) begin n_bad++; $display("FAIL empty_read_value: got %h want 00", read_value_o); end
        n_cmp++; if (search_valid_o !== 1'b0) begin n_bad++; $display("FAIL zero_key_search_valid: got %b want 0", search_valid_o); end
    endtask

    task automatic test_write_search();
        step(0, 1, 2, 8'hA5, 0, 0, 0, 0);
        step(0, 1, 5, 8'hA5, 0, 0, 0, 0);
        step(0, 1, 7, 8'h3C, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'hA5);
        n_cmp++; if (search_valid_o !== 1'b1) begin n_bad++; $display("FAIL search_a5_valid: got %b want 1", search_valid_o); end
        n_cmp++; if (search_index_o !== 3'd2) begin n_bad++; $display("FAIL search_a5_lowest: got %0d want 2", search_index_o); end
        step(0, 0, 0, 0, 1, 7, 0, 0);
        n_cmp++; if (read_value_o !== 8'h3C) begin n_bad++; $display("FAIL read7_value: got %h want 3c", read_value_o); end
        n_cmp++; if (read_valid_o !== 1'b1) begin n_bad++; $display("FAIL read7_valid: got %b want 1", read_valid_o); end
    endtask

    task automatic test_same_cycle();
        step(0, 1, 1, 8'h77, 1, 1, 1, 8'h77);
`ifdef CAM_WRITE_BYPASS_EN
        n_cmp++; if (search_valid_o !== 1'b1) begin n_bad++; $display("FAIL bypass_search_valid: got %b want 1", search_valid_o); end
        n_cmp++; if (search_index_o !== 3'd1) begin n_bad++; $display("FAIL bypass_search_index: got %0d want 1", search_index_o); end
        n_cmp++; if (read_valid_o !== 1'b1) begin n_bad++; $display("FAIL bypass_read_valid: got %b want 1", read_valid_o); end
        n_cmp++; if (read_value_o !== 8'h77) begin n_bad++; $display("FAIL bypass_read_value: got %h want 77", read_value_o); end
`else
        n_cmp++; if (search_valid_o !== 1'b0) begin n_bad++; $display("FAIL nobypass_search_valid: got %b want 0", search_valid_o); end
        n_cmp++; if (read_valid_o !== 1'b0) begin n_bad++; $display("FAIL nobypass_read_valid: got %b want 0", read_valid_o); end
        n_cmp++; if (read_value_o !== 8'h00) begin n_bad++; $display("FAIL nobypass_read_value: got %h want 00", read_value_o); end
`endif
        step(0, 0, 0, 0, 1, 1, 1, 8'h77);
        n_cmp++; if (search_valid_o !== 1'b1) begin n_bad++; $display("FAIL after_write_search_valid: got %b want 1", search_valid_o); end
        n_cmp++; if (search_index_o !== 3'd1) begin n_bad++; $display("FAIL after_write_search_index: got %0d want 1", search_index_o); end
        n_cmp++; if (read_value_o !== 8'h77) begin n_bad++; $display("FAIL after_write_read_value: got %h want 77", read_value_o); end
    endtask

    task automatic test_overwrite();
        step(0, 1, 2, 8'h11, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 8'hA5);
        n_cmp++; if (search_index_o !== 3'd5) begin n_bad++; $display("FAIL overwrite_search_index: got %0d want 5", search_index_o); end
        n_cmp++; if (search_valid_o !== 1'b1) begin n_bad++; $display("FAIL overwrite_search_valid: got %b want 1", search_valid_o); end
        // Also check that the read data holds when no read is issued
        n_cmp++; if (read_value_o !== 8'h77) begin n_bad++; $display("FAIL read_value_hold: got %h want 77", read_value_o); end
        step(0, 0, 0, 0, 0, 0, 1, 8'hFF);
        n_cmp++; if (search_valid_o !== 1'b0) begin n_bad++; $display("FAIL nomatch_search_valid: got %b want 0", search_valid_o); end
        n_cmp++; if (search_index_o !== 3'd0) begin n_bad++; $display("FAIL nomatch_search_index: got %0d want 0", search_index_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) begin
            logic [SIZE-1:0] key;
            key = ($urandom_range(0, 1) == 0) ? m_mem[i] : SIZE'($urandom);
            step(0, 0, 0, 0, 1, IW'(i), 1, key);
            n_cmp++; if (read_valid_o !== exp_rvalid || read_value_o !== exp_rv) begin
                n_bad++; $display("FAIL b2b_read[%0d]: got %b/%h want %b/%h", i, read_valid_o, read_value_o, exp_rvalid, exp_rv);
            end
            n_cmp++; if (search_valid_o !== exp_svalid || search_index_o !== exp_sidx) begin
                n_bad++; $display("FAIL b2b_search[%0d]: got %b/%0d want %b/%0d", i, search_valid_o, search_index_o, exp_svalid, exp_sidx);
            end
        end
    endtask

    task automatic test_reset_inflight();
        step(0, 0, 0, 0, 0, 0, 1, 8'hA5);
        n_cmp++; if (search_valid_o !== 1'b1 || search_index_o !== 3'd5) begin
            n_bad++; $display("FAIL pre_reset_search: got %b/%0d want 1/5", search_valid_o, search_index_o);
        end
        // Reset wins over a search and a write issued in the same cycle
        step(1, 1, 3, 8'hA5, 1, 5, 1, 8'hA5);
        n_cmp++; if (search_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_flush_search_valid: got %b want 0", search_valid_o); end
        n_cmp++; if (read_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_flush_read_valid: got %b want 0", read_valid_o); end
        step(0, 0, 0, 0, 1, 5, 1, 8'hA5);
        n_cmp++; if (read_valid_o !== 1'b0) begin n_bad++; $display("FAIL post_reset_read_valid: got %b want 0", read_valid_o); end
        n_cmp++; if (read_value_o !== 8'h00) begin n_bad++; $display("FAIL post_reset_read_value: got %h want 00", read_value_o); end
        n_cmp++; if (search_valid_o !== 1'b0) begin n_bad++; $display("FAIL post_reset_search_valid: got %b want 0", search_valid_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            // A narrow data range makes duplicates and hits common
            step(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1, IW'($urandom),
                 SIZE'($urandom_range(0, 5)), $urandom_range(0, 3) != 0, IW'($urandom),
                 $urandom_range(0, 3) != 0, SIZE'($urandom_range(0, 6)));
            n_cmp++; if (read_valid_o !== exp_rvalid) begin n_bad++; $display("FAIL rnd_read_valid @%0d: got %b want %b", n, read_valid_o, exp_rvalid); end
            n_cmp++; if (read_value_o !== exp_rv) begin n_bad++; $display("FAIL rnd_read_value @%0d: got %h want %h", n, read_value_o, exp_rv); end
            n_cmp++; if (search_valid_o !== exp_svalid) begin n_bad++; $display("FAIL rnd_search_valid @%0d: got %b want %b", n, search_valid_o, exp_svalid); end
            n_cmp++; if (search_index_o !== exp_sidx) begin n_bad++; $display("FAIL rnd_search_index @%0d: got %0d want %0d", n, search_index_o, exp_sidx); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_valid[i] = 1'b0; end
        test_reset();
        test_write_search();
        test_same_cycle();
        test_overwrite();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
